multi_inc_register: RTL

- Bank of NUM_CH independent up/down counting registers (per-core program counters, loop counters) for the multicore CPU.
- Generalises the single-channel increment register:
  - per-channel write, increment, decrement and synchronous clear;
  - parametrised step;
  - wrap or saturate mode;
  - sticky overflow/underflow flag;
  - global hold.
- Sits between each core's control unit and its instruction-fetch/AR logic.

---
 rtl/multi_inc_register_pkg.sv | 23 ++
 rtl/multi_inc_register_if.sv | 28 ++
 rtl/inc_register_channel.sv | 98 +++++++++
 rtl/multi_inc_register.sv | 50 +++++
 4 files changed

// File: rtl/multi_inc_register_pkg.sv
// Shared definitions for the multi-channel counting register bank.
// Op-priority encodings are used by the channel datapath and the bench.
package multi_inc_register_pkg;

  typedef enum logic [2:0] {
    OP_NOP = 3'd0,
    OP_CLR = 3'd1,
    OP_WR  = 3'd2,
    OP_INC = 3'd3,
    OP_DEC = 3'd4
  } op_e;

  // Priority: clear > write > exclusive inc/dec > nothing.
  function automatic op_e decode_op(input logic clr, input logic wr,
                                    input logic inc, input logic dec);
    if (clr)         return OP_CLR;
    if (wr)          return OP_WR;
    if (inc && !dec) return OP_INC;
    if (dec && !inc) return OP_DEC;
    return OP_NOP;
  endfunction

endpackage

// File: rtl/multi_inc_register_if.sv
// Control/data bundle between a core's control unit and its counter bank.
interface multi_inc_register_if #(
  parameter int unsigned WIDTH  = 12,
  parameter int unsigned NUM_CH = 4
);
  logic                    hold;
  logic [NUM_CH*WIDTH-1:0] dataIn;
  logic [NUM_CH-1:0]       writeEn;
  logic [NUM_CH-1:0]       incEn;
  logic [NUM_CH-1:0]       decEn;
  logic [NUM_CH-1:0]       clearEn;
  logic [NUM_CH-1:0]       flagClr;
  logic [NUM_CH*WIDTH-1:0] dataOut;
  logic [NUM_CH-1:0]       atZero;
  logic [NUM_CH-1:0]       atMax;
  logic [NUM_CH-1:0]       ovf;
  logic [NUM_CH-1:0]       unf;

  modport master (
    output hold, dataIn, writeEn, incEn, decEn, clearEn, flagClr,
    input  dataOut, atZero, atMax, ovf, unf
  );

  modport slave (
    input  hold, dataIn, writeEn, incEn, decEn, clearEn, flagClr,
    output dataOut, atZero, atMax, ovf, unf
  );
endinterface

// File: rtl/inc_register_channel.sv
// One up/down counting register with sticky overflow/underflow flags.
module inc_register_channel
  import multi_inc_register_pkg::*;
#(
  parameter int unsigned WIDTH     = 12,
  parameter int unsigned STEP      = 1,
  parameter int unsigned SATURATE  = 0,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             wr_i,
  input  logic             inc_i,
  input  logic             dec_i,
  input  logic             clr_i,
  input  logic             flag_clr_i,
  output logic [WIDTH-1:0] data_o,
  output logic             at_zero_o,
  output logic             at_max_o,
  output logic             ovf_o,
  output logic             unf_o
);

  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] RST_W  = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] MAX_W  = '1;
  localparam logic [WIDTH-1:0] ZERO_W = '0;

  logic [WIDTH-1:0] val_q, val_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] diff;
  op_e              op;

  assign op   = decode_op(clr_i, wr_i, inc_i, dec_i);
  assign sum  = {1'b0, val_q} + {1'b0, STEP_W};
  assign diff = val_q - STEP_W;

  // Flag clear is applied first so a same-cycle overflow/underflow still sets.
  always_comb begin
    val_d = val_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (!hold_i) begin
      if (flag_clr_i) begin
        ovf_d = 1'b0;
        unf_d = 1'b0;
      end
      case (op)
        OP_CLR: val_d = RST_W;
        OP_WR: begin
          val_d = data_i;
          ovf_d = 1'b0;
          unf_d = 1'b0;
        end
        OP_INC: begin
          if (sum[WIDTH]) begin
            ovf_d = 1'b1;
            val_d = (SATURATE != 0) ? MAX_W : sum[WIDTH-1:0];
          end else begin
            val_d = sum[WIDTH-1:0];
          end
        end
        OP_DEC: begin
          if (val_q < STEP_W) begin
            unf_d = 1'b1;
            val_d = (SATURATE != 0) ? ZERO_W : diff;
          end else begin
            val_d = diff;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val_q <= RST_W;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      val_q <= val_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign data_o    = val_q;
  assign ovf_o     = ovf_q;
  assign unf_o     = unf_q;
  assign at_zero_o = (val_q == ZERO_W);
  assign at_max_o  = (val_q == MAX_W);

endmodule

// File: rtl/multi_inc_register.sv
// Bank of NUM_CH independent counting registers sharing clock, reset and hold.
module multi_inc_register #(
  parameter int unsigned WIDTH     = 12,
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned STEP      = 1,
  parameter int unsigned SATURATE  = 0,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic                  clock,
  input  logic                  rst,
  multi_inc_register_if.slave   bus
);

  logic [NUM_CH*WIDTH-1:0] data_out;
  logic [NUM_CH-1:0]       at_zero;
  logic [NUM_CH-1:0]       at_max;
  logic [NUM_CH-1:0]       ovf;
  logic [NUM_CH-1:0]       unf;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    inc_register_channel #(
      .WIDTH     (WIDTH),
      .STEP      (STEP),
      .SATURATE  (SATURATE),
      .RESET_VAL (RESET_VAL)
    ) u_ch (
      .clk        (clock),
      .rst        (rst),
      .hold_i     (bus.hold),
      .data_i     (bus.dataIn[i*WIDTH +: WIDTH]),
      .wr_i       (bus.writeEn[i]),
      .inc_i      (bus.incEn[i]),
      .dec_i      (bus.decEn[i]),
      .clr_i      (bus.clearEn[i]),
      .flag_clr_i (bus.flagClr[i]),
      .data_o     (data_out[i*WIDTH +: WIDTH]),
      .at_zero_o  (at_zero[i]),
      .at_max_o   (at_max[i]),
      .ovf_o      (ovf[i]),
      .unf_o      (unf[i])
    );
  end

  assign bus.dataOut = data_out;
  assign bus.atZero  = at_zero;
  assign bus.atMax   = at_max;
  assign bus.ovf     = ovf;
  assign bus.unf     = unf;

endmodule
